// File: rtl/bus_pkg.sv
// Shared bus-side types and default widths used by the memory bus arbiter
// and by the cache/fetch units that sit on the same bus.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } arb_state_t;

  localparam int BUS_TAG_W  = 13;
  localparam int BUS_DATA_W = 64;
  localparam int BUS_BEATS  = 8;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Round-robin picker: returns the first set request found scanning upward
// from last+1, wrapping modulo N.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate back towards last+1 so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IW'((int'(last) + i) % N);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one split-transaction memory bus among NCLIENT
// requesters; forwards the granted request and routes its response burst back.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter  int NCLIENT = 4,
  parameter  int ADDR_W  = 64,
  parameter  int DATA_W  = BUS_DATA_W,
  parameter  int TAG_W   = BUS_TAG_W,
  parameter  int BEATS   = BUS_BEATS,
  localparam int GW      = $clog2(NCLIENT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCLIENT-1:0]         reqcyc,
  input  logic [NCLIENT*ADDR_W-1:0]  req,
  input  logic [NCLIENT*TAG_W-1:0]   reqtag,
  output logic [NCLIENT-1:0]         reqack,
  output logic [NCLIENT-1:0]         respcyc,
  output logic [DATA_W-1:0]          resp,
  output logic [TAG_W-1:0]           resptag,
  input  logic [NCLIENT-1:0]         respack,
  output logic                       bus_reqcyc,
  output logic [ADDR_W-1:0]          bus_req,
  output logic [TAG_W-1:0]           bus_reqtag,
  input  logic                       bus_reqack,
  input  logic                       bus_respcyc,
  input  logic [DATA_W-1:0]          bus_resp,
  input  logic [TAG_W-1:0]           bus_resptag,
  output logic                       bus_respack,
  output logic [GW-1:0]              grant_id,
  output logic                       tag_err
);

  localparam int CW = $clog2(BEATS) + 1;

  arb_state_t        state_q, state_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [GW-1:0]     last_q, last_d;
  logic [ADDR_W-1:0] lat_req_q, lat_req_d;
  logic [TAG_W-1:0]  lat_tag_q, lat_tag_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tag_err_q, tag_err_d;

  logic              pick_valid;
  logic [GW-1:0]     pick_idx;
  logic              beat_done;

  rr_pick #(.N(NCLIENT)) u_pick (
    .req   (reqcyc),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign beat_done = (state_q == RESP) && bus_respcyc && respack[gnt_q];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    lat_req_d = lat_req_q;
    lat_tag_d = lat_tag_q;
    cnt_d     = cnt_q;
    tag_err_d = tag_err_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d     = pick_idx;
          lat_req_d = req[pick_idx*ADDR_W +: ADDR_W];
          lat_tag_d = reqtag[pick_idx*TAG_W +: TAG_W];
          state_d   = REQ;
        end
      end
      REQ: begin
        if (bus_reqack) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        // A mismatched tag is flagged but the beat is still delivered to the client.
        if (beat_done) begin
          cnt_d = cnt_q + 1'b1;
          if (bus_resptag != lat_tag_q) begin
            tag_err_d = 1'b1;
          end
          if (cnt_q == CW'(BEATS - 1)) begin
            last_d  = gnt_q;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= GW'(NCLIENT - 1);
      lat_req_q <= '0;
      lat_tag_q <= '0;
      cnt_q     <= '0;
      tag_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      lat_req_q <= lat_req_d;
      lat_tag_q <= lat_tag_d;
      cnt_q     <= cnt_d;
      tag_err_q <= tag_err_d;
    end
  end

  // Reset blanks every output, including those of a burst being abandoned.
  always_comb begin
    reqack      = '0;
    respcyc     = '0;
    resp        = '0;
    resptag     = '0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    if (!reset) begin
      case (state_q)
        REQ: begin
          bus_reqcyc     = 1'b1;
          bus_req        = lat_req_q;
          bus_reqtag     = lat_tag_q;
          reqack[gnt_q]  = bus_reqack;
        end
        RESP: begin
          respcyc[gnt_q] = bus_respcyc;
          resp           = bus_resp;
          resptag        = bus_resptag;
          bus_respack    = respack[gnt_q];
        end
        default: ;
      endcase
    end
  end

  assign grant_id = reset ? '0 : gnt_q;
  assign tag_err  = reset ? 1'b0 : tag_err_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: rounds of client requests are turned
// into expected grants/beats by a round-robin model and checked by a monitor.
module tb_bus_rr_arbiter;

  localparam int NC = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TW = 13;
  localparam int BT = 8;
  localparam int GW = $clog2(NC);

  typedef struct {
    int            client;
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
  } reqExp_t;

  typedef struct {
    int            client;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } beatExp_t;

  logic clk = 1'b0;
  logic reset;
  logic [NC-1:0]    reqcyc;
  logic [NC*AW-1:0] req;
  logic [NC*TW-1:0] reqtag;
  logic [NC-1:0]    reqack;
  logic [NC-1:0]    respcyc;
  logic [DW-1:0]    resp;
  logic [TW-1:0]    resptag;
  logic [NC-1:0]    respack;
  logic             bus_reqcyc;
  logic [AW-1:0]    bus_req;
  logic [TW-1:0]    bus_reqtag;
  logic             bus_reqack;
  logic             bus_respcyc;
  logic [DW-1:0]    bus_resp;
  logic [TW-1:0]    bus_resptag;
  logic             bus_respack;
  logic [GW-1:0]    grant_id;
  logic             tag_err;

  int checkCount = 0;
  int passCount  = 0;

  reqExp_t  expReq[$];
  beatExp_t expBeat[$];
  int       lastServed = NC - 1;
  logic     expTagErr  = 1'b0;
  logic [AW-1:0] clientAddr [NC];
  logic [TW-1:0] clientTag  [NC];

  bit respPhase   = 1'b0;
  bit allZero     = 1'b0;
  int curClient   = 0;
  bit useFixedData = 1'b0;
  int ackDelay    = -1;
  int stallBeat   = -1;
  int stallLen    = 0;

  bus_rr_arbiter #(
    .NCLIENT(NC), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .BEATS(BT)
  ) dut (
    .clk(clk), .reset(reset),
    .reqcyc(reqcyc), .req(req), .reqtag(reqtag), .reqack(reqack),
    .respcyc(respcyc), .resp(resp), .resptag(resptag), .respack(respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .grant_id(grant_id), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge and pops expectations on each handshake.
  initial begin
    reqExp_t  re;
    beatExp_t be;
    logic [NC-1:0] oh;
    forever begin
      @(negedge clk);
      if (allZero) begin
        checkOutput("resetZeroCtl", {reqack, respcyc, bus_reqcyc, bus_respack, grant_id, tag_err}, '0);
        checkOutput("resetZeroResp", {resp, resptag}, '0);
        checkOutput("resetZeroBus", {bus_req, bus_reqtag}, '0);
      end else begin
        if (bus_reqcyc && bus_reqack) begin
          if (expReq.size() == 0) begin
            checkOutput("unexpectedReq", bus_reqcyc, 1'b0);
          end else begin
            re = expReq.pop_front();
            oh = NC'(1) << re.client;
            checkOutput("busReq", bus_req, re.addr);
            checkOutput("busReqTag", bus_reqtag, re.tag);
            checkOutput("reqAck", reqack, oh);
            checkOutput("grantId", grant_id, re.client);
          end
        end else begin
          checkOutput("reqAckIdle", reqack, '0);
        end
        if (respPhase) begin
          oh = bus_respcyc ? (NC'(1) << curClient) : '0;
          checkOutput("respcyc", respcyc, oh);
          checkOutput("busRespAck", bus_respack, respack[curClient]);
        end else begin
          checkOutput("respcycIdle", respcyc, '0);
          checkOutput("busRespAckIdle", bus_respack, 1'b0);
        end
        if (bus_respcyc && bus_respack) begin
          if (expBeat.size() == 0) begin
            checkOutput("unexpectedBeat", bus_respack, 1'b0);
          end else begin
            be = expBeat.pop_front();
            checkOutput("beatRespcyc", respcyc, NC'(1) << be.client);
            checkOutput("beatData", resp, be.data);
            checkOutput("beatTag", resptag, be.tag);
          end
        end
      end
    end
  end

  // Plays the bus side of one transaction for client c; may inject a reset mid-burst.
  task automatic serveOne(input int c, input int resetBeat, input int badBeat, input bit drop,
                          output bit wasReset);
    int waited;
    int delay;
    int stall;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    beatExp_t be;
    wasReset = 1'b0;
    waited = 0;
    while (bus_reqcyc !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("reqLatency", waited, 1);
    if (bus_reqcyc !== 1'b1) return;
    if (drop) reqcyc[c] = 1'b0;
    delay = (ackDelay >= 0) ? ackDelay : $urandom_range(0, 3);
    repeat (delay) begin
      bus_respcyc = 1'($urandom_range(0, 1));
      respack = NC'($urandom);
      tick();
    end
    bus_reqack = 1'b1;
    tick();
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    respack     = '0;
    reqcyc[c]   = 1'b0;
    curClient   = c;
    respPhase   = 1'b1;
    for (int b = 0; b < BT; b++) begin
      if (b == resetBeat) begin
        respPhase   = 1'b0;
        allZero     = 1'b1;
        bus_respcyc = 1'b1;
        bus_resp    = {$urandom, $urandom};
        respack     = '1;
        reset       = 1'b1;
        tick();
        reset       = 1'b0;
        bus_respcyc = 1'b0;
        respack     = '0;
        reqcyc      = '0;
        tick();
        allZero     = 1'b0;
        lastServed  = NC - 1;
        expTagErr   = 1'b0;
        expReq.delete();
        expBeat.delete();
        wasReset = 1'b1;
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        respack = NC'($urandom);
        tick();
      end
      data = useFixedData ? DW'(32'hA0 + b) : {$urandom, $urandom};
      tag  = (b == badBeat) ? clientTag[c] + 1'b1 : clientTag[c];
      if (tag != clientTag[c]) expTagErr = 1'b1;
      bus_respcyc = 1'b1;
      bus_resp    = data;
      bus_resptag = tag;
      be.client = c;
      be.data   = data;
      be.tag    = tag;
      expBeat.push_back(be);
      stall = (b == stallBeat) ? stallLen : $urandom_range(0, 1);
      repeat (stall) begin
        respack = NC'($urandom);
        respack[c] = 1'b0;
        tick();
      end
      respack = NC'($urandom);
      respack[c] = 1'b1;
      tick();
      bus_respcyc = 1'b0;
      respack     = '0;
    end
    respPhase = 1'b0;
  endtask

  // One round: the model orders the requesting clients round-robin after the last served one.
  task automatic applyStimulus(input logic [NC-1:0] clients, input bit randPayload,
                               input int resetBeat, input int badBeat, input bit drop);
    int order[$];
    int c;
    bit wasReset;
    reqExp_t re;
    for (int k = 1; k <= NC; k++) begin
      c = (lastServed + k) % NC;
      if (clients[c]) order.push_back(c);
    end
    for (int i = 0; i < order.size(); i++) begin
      c = order[i];
      if (randPayload) begin
        clientAddr[c] = {$urandom, $urandom};
        clientTag[c]  = TW'($urandom);
      end
      re.client = c;
      re.addr   = clientAddr[c];
      re.tag    = clientTag[c];
      expReq.push_back(re);
      req[c*AW +: AW]    = clientAddr[c];
      reqtag[c*TW +: TW] = clientTag[c];
      reqcyc[c] = 1'b1;
    end
    for (int i = 0; i < order.size(); i++) begin
      serveOne(order[i], resetBeat, badBeat, drop, wasReset);
      if (wasReset) break;
      lastServed = order[i];
      checkOutput("tagErr", tag_err, expTagErr);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    reqcyc = '0;
    req = '0;
    reqtag = '0;
    respack = '0;
    bus_reqack = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp = '0;
    bus_resptag = '0;
    for (int i = 0; i < NC; i++) begin
      clientAddr[i] = '0;
      clientTag[i]  = '0;
    end
    allZero = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    allZero = 1'b0;

    $display("[TB] single request from client 0");
    clientAddr[0] = 64'h1000;
    clientTag[0]  = 13'd5;
    useFixedData  = 1'b1;
    ackDelay      = 2;
    applyStimulus(4'b0001, 1'b0, -1, -1, 1'b0);
    useFixedData  = 1'b0;
    ackDelay      = -1;

    $display("[TB] three-cycle response stall");
    stallBeat = 2;
    stallLen  = 3;
    applyStimulus(4'b1000, 1'b1, -1, -1, 1'b0);
    stallBeat = -1;

    $display("[TB] random rounds");
    repeat (25) applyStimulus(NC'($urandom_range(1, 15)), 1'b1, -1, -1, 1'b0);

    $display("[TB] tag mismatch on beat 4");
    clientAddr[0] = {$urandom, $urandom};
    clientTag[0]  = 13'd5;
    applyStimulus(4'b0001, 1'b0, -1, 4, 1'b0);
    repeat (2) applyStimulus(4'b1111, 1'b1, -1, -1, 1'b0);

    $display("[TB] reset during beat 3");
    applyStimulus(4'b0010, 1'b1, 3, -1, 1'b0);
    applyStimulus(4'b1100, 1'b1, -1, -1, 1'b0);

    $display("[TB] client 1 drops reqcyc before bus accept");
    applyStimulus(4'b0010, 1'b1, -1, -1, 1'b1);

    $display("[TB] random rounds with tag errors");
    repeat (10) applyStimulus(NC'($urandom_range(1, 15)), 1'b1, -1, $urandom_range(0, 15), 1'b0);

    tick();
    checkOutput("expReqDrained", expReq.size(), 0);
    checkOutput("expBeatDrained", expBeat.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
